// File: rtl/shift_periph_seq_pkg.sv
// Shared constants and types for the sequential shifter peripheral:
// register map, shift modes, STATUS bit positions and FSM states.
package shift_periph_pkg;

  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] REG_DATA   = 2'b01;
  localparam logic [1:0] REG_RESULT = 2'b10;
  localparam logic [1:0] REG_STATUS = 2'b11;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_ZERO  = 3;
  localparam int ST_ERR   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_periph_seq_step.sv
// Combinational single-bit shifter: one step of LSL/LSR/ASR/ROR,
// returning the next register value and the bit shifted out.
module shift_step
  import shift_periph_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] shreg,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] shreg_next,
  output logic             out_bit
);

  // One shift step selected by mode
  always_comb begin
    shreg_next = shreg;
    out_bit    = 1'b0;
    case (mode)
      MODE_LSL: begin
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
        out_bit    = shreg[WIDTH-1];
      end
      MODE_LSR: begin
        shreg_next = {1'b0, shreg[WIDTH-1:1]};
        out_bit    = shreg[0];
      end
      MODE_ASR: begin
        shreg_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        out_bit    = shreg[0];
      end
      MODE_ROR: begin
        shreg_next = {shreg[0], shreg[WIDTH-1:1]};
        out_bit    = shreg[0];
      end
      default: begin
        shreg_next = shreg;
        out_bit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_periph_seq.sv
// Memory-mapped serial shifter: bus decode, CTRL/DATA/RESULT/STATUS
// registers and the IDLE/SHIFT sequencer, one bit shifted per clock.
module shift_periph_seq
  import shift_periph_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cs,
  input  logic             we,
  output logic [WIDTH-1:0] data_out,
  output logic             irq
);

  state_t             state_r, state_s;
  logic [1:0]         mode_r, op_mode_r;
  logic [AMT_W-1:0]   amount_r, cnt_r;
  logic               irq_en_r;
  logic [WIDTH-1:0]   operand_r, shreg_r, result_r;
  logic               busy_r, done_r, carry_r, zero_r, err_r;
  logic               wr_ctrl_s, wr_data_s, wr_status_s;
  logic               start_s, shift_s, finish_s, collide_s;
  logic [WIDTH-1:0]   step_next_s, ctrl_rd_s, status_rd_s;
  logic               step_out_s;

  assign wr_ctrl_s   = cs & we & (reg_sel == REG_CTRL);
  assign wr_data_s   = cs & we & (reg_sel == REG_DATA);
  assign wr_status_s = cs & we & (reg_sel == REG_STATUS);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .shreg      (shreg_r),
    .mode       (op_mode_r),
    .shreg_next (step_next_s),
    .out_bit    (step_out_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next state and per-cycle action strobes
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    shift_s   = 1'b0;
    finish_s  = 1'b0;
    collide_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_data_s) begin
          start_s = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        collide_s = wr_data_s;
        if (cnt_r == {AMT_W{1'b0}}) begin
          finish_s = 1'b1;
          state_s  = IDLE;
        end else begin
          shift_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // CTRL register, writable at any time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r   <= 2'b00;
      amount_r <= {AMT_W{1'b0}};
      irq_en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      mode_r   <= data_in[1:0];
      amount_r <= data_in[AMT_W+1:2];
      irq_en_r <= data_in[WIDTH-1];
    end
  end

  // Operand capture, serial shifting and result latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_r <= {WIDTH{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      cnt_r     <= {AMT_W{1'b0}};
      op_mode_r <= 2'b00;
      carry_r   <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      if (start_s) begin
        operand_r <= data_in;
        shreg_r   <= data_in;
        cnt_r     <= amount_r;
        op_mode_r <= mode_r;
        carry_r   <= 1'b0;
      end else if (shift_s) begin
        shreg_r <= step_next_s;
        carry_r <= step_out_s;
        cnt_r   <= cnt_r - AMT_W'(1);
      end
      if (finish_s) begin
        result_r <= shreg_r;
        zero_r   <= (shreg_r == {WIDTH{1'b0}});
      end
    end
  end

  // Busy/done/err flags; a completion outranks a same-cycle done clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (start_s)       busy_r <= 1'b1;
      else if (finish_s) busy_r <= 1'b0;
      if (finish_s)                                           done_r <= 1'b1;
      else if (start_s || (wr_status_s && data_in[ST_DONE]))  done_r <= 1'b0;
      if (collide_s)                             err_r <= 1'b1;
      else if (wr_status_s && data_in[ST_ERR])   err_r <= 1'b0;
    end
  end

  // Read-back images and combinational read mux
  always_comb begin
    ctrl_rd_s              = {WIDTH{1'b0}};
    ctrl_rd_s[1:0]         = mode_r;
    ctrl_rd_s[AMT_W+1:2]   = amount_r;
    ctrl_rd_s[WIDTH-1]     = irq_en_r;
    status_rd_s            = {WIDTH{1'b0}};
    status_rd_s[ST_BUSY]   = busy_r;
    status_rd_s[ST_DONE]   = done_r;
    status_rd_s[ST_CARRY]  = carry_r;
    status_rd_s[ST_ZERO]   = zero_r;
    status_rd_s[ST_ERR]    = err_r;
    data_out               = {WIDTH{1'b0}};
    if (cs && !we) begin
      case (reg_sel)
        REG_CTRL:   data_out = ctrl_rd_s;
        REG_DATA:   data_out = operand_r;
        REG_RESULT: data_out = result_r;
        REG_STATUS: data_out = status_rd_s;
        default:    data_out = {WIDTH{1'b0}};
      endcase
    end else begin
      data_out = {WIDTH{1'b0}};
    end
  end

  assign irq = done_r & irq_en_r;

endmodule

// File: tb/tb_shift_periph_seq.sv
// Self-checking bench for shift_periph_seq (WIDTH=16): directed plan cases
// plus randomized operations checked against an arithmetic shift model.
module tb_shift_periph_seq;

  localparam int W = 16;
  localparam logic [1:0] S_CTRL = 2'b00, S_DATA = 2'b01, S_RES = 2'b10, S_STAT = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   reg_sel;
  logic [W-1:0] data_in;
  logic         cs, we;
  logic [W-1:0] data_out;
  logic         irq;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic m_err    = 1'b0;

  shift_periph_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .reg_sel(reg_sel), .data_in(data_in),
    .cs(cs), .we(we), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: whole shift done at once with shift operators
  function automatic void model(input logic [1:0] m, input int amt, input logic [W-1:0] op,
                                output logic [W-1:0] res, output logic c);
    res = op;
    c   = 1'b0;
    if (amt != 0) begin
      case (m)
        2'd0: begin res = op << amt; c = op[W-amt]; end
        2'd1: begin res = op >> amt; c = op[amt-1]; end
        2'd2: begin res = W'($signed(op) >>> amt); c = op[amt-1]; end
        default: begin res = (op >> amt) | (op << (W-amt)); c = op[amt-1]; end
      endcase
    end
  endfunction

  task automatic bus_write(input logic [1:0] sel, input logic [W-1:0] d);
    cs = 1'b1; we = 1'b1; reg_sel = sel; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [W-1:0] d);
    cs = 1'b1; we = 1'b0; reg_sel = sel;
    #1 d = data_out;
    cs = 1'b0;
    #1;
  endtask

  // Full operation with per-cycle busy/done latency and final register checks
  task automatic run_op(input string nm, input logic [1:0] m, input logic [3:0] amt,
                        input logic [W-1:0] op, input logic ien);
    logic [W-1:0] exp_res, v, ctrl, exp_st;
    logic exp_c;
    model(m, int'(amt), op, exp_res, exp_c);
    ctrl = '0; ctrl[1:0] = m; ctrl[5:2] = amt; ctrl[15] = ien;
    bus_write(S_CTRL, ctrl);
    bus_read(S_CTRL, v);
    n_checks++; if (v !== ctrl) $display("FAIL %s ctrl_rb: got %h want %h", nm, v, ctrl); else n_pass++;
    bus_write(S_DATA, op);
    for (int k = 0; k <= int'(amt); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus_read(S_STAT, v);
      n_checks++; if (v[1:0] !== 2'b01 || irq !== 1'b0) $display("FAIL %s busy_c%0d: got st=%h irq=%b want busy only", nm, k, v[1:0], irq); else n_pass++;
    end
    @(posedge clk); #1;
    bus_read(S_STAT, v);
    exp_st = '0; exp_st[1] = 1'b1; exp_st[2] = exp_c; exp_st[3] = (exp_res == '0); exp_st[4] = m_err;
    n_checks++; if (v !== exp_st) $display("FAIL %s status: got %h want %h", nm, v, exp_st); else n_pass++;
    n_checks++; if (irq !== ien) $display("FAIL %s irq: got %b want %b", nm, irq, ien); else n_pass++;
    bus_read(S_RES, v);
    n_checks++; if (v !== exp_res) $display("FAIL %s result: got %h want %h", nm, v, exp_res); else n_pass++;
    bus_read(S_DATA, v);
    n_checks++; if (v !== op) $display("FAIL %s operand: got %h want %h", nm, v, op); else n_pass++;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset = 1'b1; cs = 1'b0; we = 1'b0; reg_sel = 2'b00; data_in = '0;
    repeat (2) @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      bus_read(2'(s), v);
      n_checks++; if (v !== '0) $display("FAIL reset_reg%0d: got %h want 0000", s, v); else n_pass++;
    end
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    logic [W-1:0] v;
    run_op("lsl1", 2'd0, 4'd1, 16'h0002, 1'b0);
    bus_read(S_RES, v);
    n_checks++; if (v !== 16'h0004) $display("FAIL lsl1_lit: got %h want 0004", v); else n_pass++;
    run_op("asr4", 2'd2, 4'd4, 16'h8010, 1'b0);
    bus_read(S_RES, v);
    n_checks++; if (v !== 16'hF801) $display("FAIL asr4_lit: got %h want f801", v); else n_pass++;
    run_op("ror1", 2'd3, 4'd1, 16'h0001, 1'b0);
    bus_read(S_STAT, v);
    n_checks++; if (v[2] !== 1'b1) $display("FAIL ror1_carry: got %b want 1", v[2]); else n_pass++;
    run_op("lsr15", 2'd1, 4'd15, 16'h8000, 1'b0);
    bus_read(S_RES, v);
    n_checks++; if (v !== 16'h0001) $display("FAIL lsr15_lit: got %h want 0001", v); else n_pass++;
    run_op("amt0", 2'd1, 4'd0, 16'hC3A5, 1'b0);
    run_op("zero", 2'd0, 4'd8, 16'h0F00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] v;
    logic timed_out;
    bus_write(S_CTRL, 16'h0021);
    bus_write(S_DATA, 16'hFF00);
    repeat (2) @(posedge clk); #1;
    bus_write(S_DATA, 16'h1234);
    m_err = 1'b1;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus_read(S_STAT, v);
      if (v[1]) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (timed_out !== 1'b0) $display("FAIL coll_timeout: done never seen within 40 cycles"); else n_pass++;
    bus_read(S_RES, v);
    n_checks++; if (v !== 16'h00FF) $display("FAIL coll_result: got %h want 00ff", v); else n_pass++;
    bus_read(S_DATA, v);
    n_checks++; if (v !== 16'hFF00) $display("FAIL coll_operand: got %h want ff00", v); else n_pass++;
    bus_read(S_STAT, v);
    n_checks++; if (v !== 16'h0012) $display("FAIL coll_status: got %h want 0012", v); else n_pass++;
    bus_write(S_STAT, 16'h0012);
    m_err = 1'b0;
    bus_read(S_STAT, v);
    n_checks++; if (v !== 16'h0000) $display("FAIL coll_clear: got %h want 0000", v); else n_pass++;
  endtask

  task automatic test_regs();
    logic [W-1:0] v;
    bus_write(S_CTRL, 16'h0000);
    bus_write(S_DATA, 16'h5A5A);
    bus_write(S_STAT, 16'h0002);
    bus_read(S_STAT, v);
    n_checks++; if (v[1] !== 1'b1) $display("FAIL done_set_wins: got %b want 1", v[1]); else n_pass++;
    bus_write(S_STAT, 16'h0002);
    bus_read(S_STAT, v);
    n_checks++; if (v[1] !== 1'b0) $display("FAIL done_clear: got %b want 0", v[1]); else n_pass++;
    bus_write(S_RES, 16'hABCD);
    bus_read(S_RES, v);
    n_checks++; if (v !== 16'h5A5A) $display("FAIL result_ro: got %h want 5a5a", v); else n_pass++;
    bus_write(S_CTRL, 16'hFFFF);
    bus_read(S_CTRL, v);
    n_checks++; if (v !== 16'h803F) $display("FAIL ctrl_mask: got %h want 803f", v); else n_pass++;
    bus_write(S_CTRL, 16'h0000);
  endtask

  task automatic test_irq_reset();
    logic [W-1:0] v;
    run_op("irq", 2'd0, 4'd1, 16'h0001, 1'b1);
    bus_write(S_DATA, 16'h00F0);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_restart: got %b want 0", irq); else n_pass++;
    reset = 1'b1;
    #2;
    bus_read(S_STAT, v);
    n_checks++; if (v !== '0) $display("FAIL rst_status: got %h want 0000", v); else n_pass++;
    bus_read(S_RES, v);
    n_checks++; if (v !== '0) $display("FAIL rst_result: got %h want 0000", v); else n_pass++;
    bus_read(S_CTRL, v);
    n_checks++; if (v !== '0) $display("FAIL rst_ctrl: got %h want 0000", v); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
    @(negedge clk); reset = 1'b0;
    m_err = 1'b0;
    repeat (20) @(posedge clk); #1;
    bus_read(S_STAT, v);
    n_checks++; if (v !== '0) $display("FAIL rst_no_done: got %h want 0000", v); else n_pass++;
    bus_read(S_RES, v);
    n_checks++; if (v !== '0) $display("FAIL rst_no_result: got %h want 0000", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_plan();
    test_regs();
    test_collision();
    test_random();
    test_irq_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
